// File: rtl/risk_tile_walker.sv
// risk_tile_walker
//   Initiator for the RISK strided tile memory. A matrix command (base, row
//   pitch, tile counts) is walked in 4x4-element tiles, row-major over tiles,
//   issuing at most one tile access per cycle. Load walks return each tile on
//   the rd_* stream RD_LAT cycles after issue; store walks pull one tile from
//   the wr_* stream per access.
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_store                   0 = load walk, 1 = store walk
//   cmd_base/cmd_ld             tile (0,0) element address / row pitch
//   cmd_tiles_x/cmd_tiles_y     tiles per tile-row / number of tile-rows
//   mem_en/mem_we/mem_addr      registered tile access toward risk_mem
//   mem_stride_x/mem_stride_y   element strides (1 / latched row pitch)
//   mem_dat_w/mem_dat_r         store data out / load data in
//   wr_valid/wr_ready/wr_tile   store tile stream
//   rd_valid/rd_last/rd_tile    load tile stream, no backpressure
//   busy/done                   walker active / one-cycle completion pulse
module risk_tile_walker #(
  parameter int ADDR_W   = 17,
  parameter int STRIDE_W = 15,
  parameter int TILE_W   = 288,
  parameter int CNT_W    = 8,
  parameter int RD_LAT   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_store,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [STRIDE_W-1:0] cmd_ld,
  input  logic [CNT_W-1:0]    cmd_tiles_x,
  input  logic [CNT_W-1:0]    cmd_tiles_y,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [STRIDE_W-1:0] mem_stride_x,
  output logic [STRIDE_W-1:0] mem_stride_y,
  output logic [TILE_W-1:0]   mem_dat_w,
  input  logic [TILE_W-1:0]   mem_dat_r,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [TILE_W-1:0]   wr_tile,
  output logic                rd_valid,
  output logic                rd_last,
  output logic [TILE_W-1:0]   rd_tile,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                store_r, store_nxt_s;
  logic [STRIDE_W-1:0] ld_r, ld_nxt_s;
  logic [CNT_W-1:0]    tiles_x_r, tiles_x_nxt_s, tiles_y_r, tiles_y_nxt_s;
  logic [CNT_W-1:0]    tx_r, tx_nxt_s, ty_r, ty_nxt_s;
  logic [ADDR_W-1:0]   col_r, col_nxt_s, row_r, row_nxt_s;
  logic                last_taken_r, last_taken_nxt_s;
  logic                mem_en_r, mem_en_nxt_s, mem_we_r, mem_we_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [TILE_W-1:0]   mem_dat_w_r, mem_dat_w_nxt_s;
  logic                mem_last_r, mem_last_nxt_s;
  logic [RD_LAT-1:0]   pipe_vld_r, pipe_last_r;
  logic                done_r, done_nxt_s;
  logic                busy_r, cmd_ready_r, wr_ready_r;

  logic                row_end_s, last_tile_s, adv_last_s;
  logic [CNT_W-1:0]    adv_tx_s, adv_ty_s;
  logic [ADDR_W-1:0]   adv_col_s, adv_row_s, ld_x4_s;

  // One tile-row down is four element rows; wraps modulo 2^ADDR_W.
  assign ld_x4_s = ADDR_W'(ld_r) << 2;

  // Successor of the current walk position in row-major tile order.
  always_comb begin
    row_end_s   = (tx_r == tiles_x_r - CNT_W'(1));
    last_tile_s = row_end_s && (ty_r == tiles_y_r - CNT_W'(1));
    if (row_end_s) begin
      adv_tx_s  = '0;
      adv_ty_s  = ty_r + CNT_W'(1);
      adv_row_s = row_r + ld_x4_s;
      adv_col_s = row_r + ld_x4_s;
    end else begin
      adv_tx_s  = tx_r + CNT_W'(1);
      adv_ty_s  = ty_r;
      adv_row_s = row_r;
      adv_col_s = col_r + ADDR_W'(4);
    end
    adv_last_s = (adv_tx_s == tiles_x_r - CNT_W'(1)) && (adv_ty_s == tiles_y_r - CNT_W'(1));
  end

  // Walk FSM next state and next values of the registered memory port.
  // Load: tx/ty/col track the tile currently shown on mem_*.
  // Store: tx/ty/col track the next tile to be issued.
  always_comb begin
    state_nxt_s      = state_r;
    store_nxt_s      = store_r;
    ld_nxt_s         = ld_r;
    tiles_x_nxt_s    = tiles_x_r;
    tiles_y_nxt_s    = tiles_y_r;
    tx_nxt_s         = tx_r;
    ty_nxt_s         = ty_r;
    col_nxt_s        = col_r;
    row_nxt_s        = row_r;
    last_taken_nxt_s = last_taken_r;
    mem_en_nxt_s     = 1'b0;
    mem_we_nxt_s     = 1'b0;
    mem_addr_nxt_s   = mem_addr_r;
    mem_dat_w_nxt_s  = mem_dat_w_r;
    mem_last_nxt_s   = 1'b0;
    done_nxt_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          store_nxt_s      = cmd_store;
          ld_nxt_s         = cmd_ld;
          tiles_x_nxt_s    = cmd_tiles_x;
          tiles_y_nxt_s    = cmd_tiles_y;
          tx_nxt_s         = '0;
          ty_nxt_s         = '0;
          col_nxt_s        = cmd_base;
          row_nxt_s        = cmd_base;
          last_taken_nxt_s = 1'b0;
          if ((cmd_tiles_x == '0) || (cmd_tiles_y == '0)) begin
            state_nxt_s = ST_FIN;
            done_nxt_s  = 1'b1;
          end else if (!cmd_store) begin
            // Tile (0,0) is issued straight off the accept edge.
            state_nxt_s    = ST_RUN;
            mem_en_nxt_s   = 1'b1;
            mem_addr_nxt_s = cmd_base;
            mem_last_nxt_s = (cmd_tiles_x == CNT_W'(1)) && (cmd_tiles_y == CNT_W'(1));
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!store_r) begin
          if (last_tile_s) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            tx_nxt_s       = adv_tx_s;
            ty_nxt_s       = adv_ty_s;
            col_nxt_s      = adv_col_s;
            row_nxt_s      = adv_row_s;
            mem_en_nxt_s   = 1'b1;
            mem_addr_nxt_s = adv_col_s;
            mem_last_nxt_s = adv_last_s;
          end
        end else if (last_taken_r) begin
          // Final store is on mem_* this cycle; done follows it.
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else if (wr_valid && wr_ready_r) begin
          mem_en_nxt_s    = 1'b1;
          mem_we_nxt_s    = 1'b1;
          mem_addr_nxt_s  = col_r;
          mem_dat_w_nxt_s = wr_tile;
          if (last_tile_s) begin
            last_taken_nxt_s = 1'b1;
          end else begin
            tx_nxt_s  = adv_tx_s;
            ty_nxt_s  = adv_ty_s;
            col_nxt_s = adv_col_s;
            row_nxt_s = adv_row_s;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Predict one cycle ahead so done lines up with rd_last.
        done_nxt_s = pipe_vld_r[RD_LAT-2] && pipe_last_r[RD_LAT-2];
        if (pipe_vld_r[RD_LAT-1] && pipe_last_r[RD_LAT-1]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, walk position, registered outputs and the read-return tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      store_r      <= 1'b0;
      ld_r         <= '0;
      tiles_x_r    <= '0;
      tiles_y_r    <= '0;
      tx_r         <= '0;
      ty_r         <= '0;
      col_r        <= '0;
      row_r        <= '0;
      last_taken_r <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_dat_w_r  <= '0;
      mem_last_r   <= 1'b0;
      pipe_vld_r   <= '0;
      pipe_last_r  <= '0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      cmd_ready_r  <= 1'b1;
      wr_ready_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      store_r      <= store_nxt_s;
      ld_r         <= ld_nxt_s;
      tiles_x_r    <= tiles_x_nxt_s;
      tiles_y_r    <= tiles_y_nxt_s;
      tx_r         <= tx_nxt_s;
      ty_r         <= ty_nxt_s;
      col_r        <= col_nxt_s;
      row_r        <= row_nxt_s;
      last_taken_r <= last_taken_nxt_s;
      mem_en_r     <= mem_en_nxt_s;
      mem_we_r     <= mem_we_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_dat_w_r  <= mem_dat_w_nxt_s;
      mem_last_r   <= mem_last_nxt_s;
      pipe_vld_r   <= {pipe_vld_r[RD_LAT-2:0], mem_en_r & ~mem_we_r};
      pipe_last_r  <= {pipe_last_r[RD_LAT-2:0], mem_last_r};
      done_r       <= done_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      // Ready stays low through the done cycle so commands never overlap.
      cmd_ready_r  <= (state_nxt_s == ST_IDLE) && !done_nxt_s;
      wr_ready_r   <= (state_nxt_s == ST_RUN) && store_nxt_s && !last_taken_nxt_s;
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign mem_en       = mem_en_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_stride_x = STRIDE_W'(1);
  assign mem_stride_y = ld_r;
  assign mem_dat_w    = mem_dat_w_r;
  assign wr_ready     = wr_ready_r;
  assign rd_valid     = pipe_vld_r[RD_LAT-1];
  assign rd_last      = pipe_vld_r[RD_LAT-1] & pipe_last_r[RD_LAT-1];
  // Memory data is only valid in its return cycle, so it is forwarded directly.
  assign rd_tile      = rd_valid ? mem_dat_r : '0;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_risk_tile_walker.sv
module tb_risk_tile_walker;
  localparam int ADDR_W   = 17;
  localparam int STRIDE_W = 15;
  localparam int TILE_W   = 288;
  localparam int CNT_W    = 8;
  localparam int RD_LAT   = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid, cmd_ready, cmd_store;
  logic [ADDR_W-1:0]   cmd_base;
  logic [STRIDE_W-1:0] cmd_ld;
  logic [CNT_W-1:0]    cmd_tiles_x, cmd_tiles_y;
  logic                mem_en, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [STRIDE_W-1:0] mem_stride_x, mem_stride_y;
  logic [TILE_W-1:0]   mem_dat_w, mem_dat_r, wr_tile, rd_tile;
  logic                wr_valid, wr_ready, rd_valid, rd_last, busy, done;

  int total = 0;
  int bad   = 0;

  // Memory model history: index 0 = current cycle, index RD_LAT = return cycle.
  logic                hist_en   [RD_LAT+1];
  logic [ADDR_W-1:0]   hist_addr [RD_LAT+1];

  always #5 clk = ~clk;

  risk_tile_walker dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_ld(cmd_ld), .cmd_tiles_x(cmd_tiles_x), .cmd_tiles_y(cmd_tiles_y),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_stride_x(mem_stride_x), .mem_stride_y(mem_stride_y),
    .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tile(wr_tile),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_tile(rd_tile),
    .busy(busy), .done(done)
  );

  // Contents the memory model returns for a tile at address a.
  function automatic logic [TILE_W-1:0] tile_of(input logic [ADDR_W-1:0] a);
    return {16{1'b1, a}};
  endfunction

  function automatic logic [TILE_W-1:0] rand_tile();
    logic [TILE_W-1:0] t;
    for (int i = 0; i < TILE_W / 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [TILE_W-1:0] obs, input logic [TILE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance one cycle: update the memory model and drive this cycle's inputs.
  task automatic step(input bit keep_cmd, input logic wv, input logic [TILE_W-1:0] wt);
    @(posedge clk);
    #1;
    for (int i = RD_LAT; i > 0; i--) begin
      hist_en[i]   = hist_en[i-1];
      hist_addr[i] = hist_addr[i-1];
    end
    hist_en[0]   = mem_en && !mem_we;
    hist_addr[0] = mem_addr;
    mem_dat_r = hist_en[RD_LAT] ? tile_of(hist_addr[RD_LAT]) : rand_tile();
    if (!keep_cmd) begin
      cmd_valid   = 1'b0;
      cmd_store   = 1'($urandom_range(0, 1));
      cmd_base    = ADDR_W'($urandom);
      cmd_ld      = STRIDE_W'($urandom);
      cmd_tiles_x = CNT_W'($urandom);
      cmd_tiles_y = CNT_W'($urandom);
    end
    wr_valid = wv;
    wr_tile  = wt;
    #1;
  endtask

  task automatic issue_cmd(input bit st, input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] ld,
                           input int nx, input int ny);
    cmd_store   = st;
    cmd_base    = base;
    cmd_ld      = ld;
    cmd_tiles_x = CNT_W'(nx);
    cmd_tiles_y = CNT_W'(ny);
    cmd_valid   = 1'b1;
    chkb("accept_ready", cmd_ready, 1'b1);
  endtask

  function automatic void build_addrs(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] ld,
                                      input int nx, input int ny, ref logic [ADDR_W-1:0] q [$]);
    q.delete();
    for (int y = 0; y < ny; y++)
      for (int x = 0; x < nx; x++)
        q.push_back(ADDR_W'((int'(base) + 4 * x + 4 * int'(ld) * y) % (1 << ADDR_W)));
  endfunction

  // Load walk: issues on cycles 1..n after accept, returns RD_LAT later.
  task automatic run_load(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] ld,
                          input int nx, input int ny, input bit keep);
    logic [ADDR_W-1:0] ea [$];
    int n;
    build_addrs(base, ld, nx, ny, ea);
    n = nx * ny;
    issue_cmd(1'b0, base, ld, nx, ny);
    for (int c = 1; c <= n + RD_LAT + 1; c++) begin
      step(keep, 1'($urandom_range(0, 1)), rand_tile());
      chkb("ld_mem_en", mem_en, c <= n);
      if (c <= n) begin
        chk("ld_addr", TILE_W'(mem_addr), TILE_W'(ea[c-1]));
        chkb("ld_we", mem_we, 1'b0);
        chk("ld_stride_y", TILE_W'(mem_stride_y), TILE_W'(ld));
        chk("ld_stride_x", TILE_W'(mem_stride_x), TILE_W'(1));
      end
      chkb("ld_rd_valid", rd_valid, (c > RD_LAT) && (c <= n + RD_LAT));
      if ((c > RD_LAT) && (c <= n + RD_LAT)) chk("ld_rd_tile", rd_tile, tile_of(ea[c-RD_LAT-1]));
      chkb("ld_rd_last", rd_last, c == n + RD_LAT);
      chkb("ld_done", done, c == n + RD_LAT);
      chkb("ld_busy", busy, c <= n + RD_LAT);
      chkb("ld_cmd_ready", cmd_ready, c == n + RD_LAT + 1);
      chkb("ld_wr_ready", wr_ready, 1'b0);
    end
  endtask

  // Store walk: bench takes a tile whenever wr_valid meets the expected wr_ready.
  task automatic run_store(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] ld,
                           input int nx, input int ny, input bit use_pat, input logic [15:0] pat);
    logic [ADDR_W-1:0] ea [$];
    logic [TILE_W-1:0] sent [$];
    logic [TILE_W-1:0] wt;
    logic wv, exp_ready;
    bit took_prev, fin;
    int n, k, last_c;
    build_addrs(base, ld, nx, ny, ea);
    n = nx * ny;
    k = 0;
    last_c = 0;
    took_prev = 1'b0;
    fin = 1'b0;
    issue_cmd(1'b1, base, ld, nx, ny);
    for (int c = 1; c <= 400; c++) begin
      if (use_pat && c <= 16) wv = pat[c-1];
      else if (c > 60) wv = 1'b1;
      else wv = 1'($urandom_range(0, 1));
      wt = rand_tile();
      step(1'b0, wv, wt);
      chkb("st_mem_en", mem_en, took_prev);
      if (took_prev) begin
        chkb("st_we", mem_we, 1'b1);
        chk("st_addr", TILE_W'(mem_addr), TILE_W'(ea[k-1]));
        chk("st_dat_w", mem_dat_w, sent[k-1]);
        chk("st_stride_y", TILE_W'(mem_stride_y), TILE_W'(ld));
      end
      exp_ready = (k < n);
      chkb("st_wr_ready", wr_ready, exp_ready);
      chkb("st_rd_valid", rd_valid, 1'b0);
      chkb("st_done", done, (last_c > 0) && (c == last_c + 2));
      chkb("st_busy", busy, (last_c == 0) || (c <= last_c + 1));
      chkb("st_cmd_ready", cmd_ready, (last_c > 0) && (c >= last_c + 3));
      if ((last_c > 0) && (c == last_c + 3)) begin
        fin = 1'b1;
        break;
      end
      took_prev = exp_ready && wv;
      if (took_prev) begin
        sent.push_back(wt);
        k++;
        if (k == n) last_c = c;
      end
    end
    chkb("st_timeout", fin, 1'b1);
  endtask

  task automatic run_zero(input int nx, input int ny);
    issue_cmd(1'b0, ADDR_W'($urandom), STRIDE_W'($urandom), nx, ny);
    step(1'b0, 1'b0, rand_tile());
    chkb("z_done", done, 1'b1);
    chkb("z_busy", busy, 1'b1);
    chkb("z_mem_en", mem_en, 1'b0);
    chkb("z_cmd_ready", cmd_ready, 1'b0);
    step(1'b0, 1'b0, rand_tile());
    chkb("z_done2", done, 1'b0);
    chkb("z_busy2", busy, 1'b0);
    chkb("z_mem_en2", mem_en, 1'b0);
    chkb("z_cmd_ready2", cmd_ready, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chkb({tag, "_mem_en"}, mem_en, 1'b0);
    chkb({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, TILE_W'(mem_addr), '0);
    chk({tag, "_stride_x"}, TILE_W'(mem_stride_x), TILE_W'(1));
    chk({tag, "_stride_y"}, TILE_W'(mem_stride_y), '0);
    chk({tag, "_dat_w"}, mem_dat_w, '0);
    chkb({tag, "_rd_valid"}, rd_valid, 1'b0);
    chkb({tag, "_rd_last"}, rd_last, 1'b0);
    chk({tag, "_rd_tile"}, rd_tile, '0);
    chkb({tag, "_done"}, done, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_wr_ready"}, wr_ready, 1'b0);
    chkb({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_store   = 1'b0;
    cmd_base    = '0;
    cmd_ld      = '0;
    cmd_tiles_x = '0;
    cmd_tiles_y = '0;
    wr_valid    = 1'b0;
    wr_tile     = '0;
    mem_dat_r   = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      hist_en[i]   = 1'b0;
      hist_addr[i] = '0;
    end
    @(posedge clk);
    #2;
    chk_reset_state("rst");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Directed: 2x2 load, 1x3 store with a stall, zero tiles, address wrap.
    run_load(17'h00100, 15'd16, 2, 2, 1'b0);
    run_store(17'h00200, 15'd32, 1, 3, 1'b1, 16'h000D);
    run_zero(0, 3);
    run_zero(2, 0);
    run_load(17'h1FFFC, 15'd4, 2, 1, 1'b0);

    // Reset in the middle of a 4-tile load after two issues.
    issue_cmd(1'b0, 17'h00400, 15'd8, 2, 2);
    step(1'b0, 1'b0, rand_tile());
    chkb("mr_issue1", mem_en, 1'b1);
    step(1'b0, 1'b0, rand_tile());
    chkb("mr_issue2", mem_en, 1'b1);
    chk("mr_addr2", TILE_W'(mem_addr), TILE_W'(17'h00404));
    #1;
    reset = 1'b1;
    #1;
    chk_reset_state("mr");
    step(1'b0, 1'b0, rand_tile());
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, rand_tile());
      chkb("mr_no_rd_valid", rd_valid, 1'b0);
      chkb("mr_no_mem_en", mem_en, 1'b0);
      chkb("mr_cmd_ready", cmd_ready, 1'b1);
    end

    // cmd_valid held across two 1x1 loads.
    run_load(17'h00040, 15'd12, 1, 1, 1'b1);
    run_load(17'h00040, 15'd12, 1, 1, 1'b0);

    // Randomized walks against the reference model.
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 2))
        0: run_load(ADDR_W'($urandom), STRIDE_W'($urandom), $urandom_range(1, 3), $urandom_range(1, 3), 1'b0);
        1: run_store(ADDR_W'($urandom), STRIDE_W'($urandom), $urandom_range(1, 3), $urandom_range(1, 3),
                     1'b0, 16'h0000);
        default: run_zero($urandom_range(0, 1) * $urandom_range(1, 3), 0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
